// File: rtl/l1_dcache_ctrl_if.sv
// l1_dcache_ctrl_if -- CPU-side and memory-side signals of the L1 data cache.
//   CPU side : MemRead_i, MemWrite_i, addr_i, wdata_i -> rdata_o, Memstall_o
//   Mem side : mem_enable_o, mem_write_o, mem_addr_o, mem_data_o -> mem_data_i, mem_ack_i
// The master modport is the environment (pipeline plus off-chip memory).
// The slave modport is the cache controller.
interface l1_dcache_ctrl_if;
    logic         MemRead_i;
    logic         MemWrite_i;
    logic [31:0]  addr_i;
    logic [31:0]  wdata_i;
    logic [31:0]  rdata_o;
    logic         Memstall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    modport master (
        output MemRead_i, MemWrite_i, addr_i, wdata_i, mem_data_i, mem_ack_i,
        input  rdata_o, Memstall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );

    modport slave (
        input  MemRead_i, MemWrite_i, addr_i, wdata_i, mem_data_i, mem_ack_i,
        output rdata_o, Memstall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/l1_dcache_ctrl.sv
// l1_dcache_ctrl -- direct-mapped, write-back, write-allocate L1 data cache
// controller with 2^INDEX_W lines of 256 bits.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset; clears valid/dirty and zeroes outputs
//   bus    : l1_dcache_ctrl_if.slave (pipeline request/stall and line-wide memory port)
// Hits in IDLE complete with zero latency. A miss stalls the pipeline, writes
// the victim back if it is dirty, fetches the new line and then lets the
// still-held request hit on return to IDLE.
//
// state   | meaning
// IDLE    | serving hits; a miss leaves this state
// WB_REQ  | first cycle of the victim write-back request
// WB_WAIT | write-back outstanding, waiting for mem_ack_i
// RD_REQ  | first cycle of the line fetch request
// RD_WAIT | fetch outstanding, waiting for mem_ack_i with fill data
module l1_dcache_ctrl #(
    parameter int INDEX_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    l1_dcache_ctrl_if.slave   bus
);
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 27 - INDEX_W;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB_REQ  = 3'd1,
        WB_WAIT = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [255:0]     data_q [LINES];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   addr_tag;
    logic [2:0]         word_sel;
    logic               req;
    logic               hit;
    logic               store_we;
    logic               fill_we;
    logic               dirty_clr;
    logic [1:0]         unused_addr_lsb;

    assign idx             = bus.addr_i[INDEX_W+4:5];
    assign addr_tag        = bus.addr_i[31:INDEX_W+5];
    assign word_sel        = bus.addr_i[4:2];
    assign unused_addr_lsb = bus.addr_i[1:0];
    assign req             = bus.MemRead_i | bus.MemWrite_i;
    assign hit             = valid_q[idx] && (tag_q[idx] == addr_tag);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        bus.Memstall_o   = 1'b0;
        bus.rdata_o      = '0;
        bus.mem_enable_o = 1'b0;
        bus.mem_write_o  = 1'b0;
        bus.mem_addr_o   = '0;
        bus.mem_data_o   = '0;
        store_we         = 1'b0;
        fill_we          = 1'b0;
        dirty_clr        = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        // A simultaneous read and write is a store.
                        if (bus.MemWrite_i) begin
                            store_we = 1'b1;
                        end else begin
                            bus.rdata_o = data_q[idx][{word_sel, 5'b0} +: 32];
                        end
                    end else begin
                        bus.Memstall_o = 1'b1;
                        state_d = (valid_q[idx] && dirty_q[idx]) ? WB_REQ : RD_REQ;
                    end
                end
            end
            WB_REQ, WB_WAIT: begin
                bus.Memstall_o   = 1'b1;
                bus.mem_enable_o = 1'b1;
                bus.mem_write_o  = 1'b1;
                bus.mem_addr_o   = {tag_q[idx], idx, 5'b0};
                bus.mem_data_o   = data_q[idx];
                if (state_q == WB_REQ) begin
                    state_d = WB_WAIT;
                end else if (bus.mem_ack_i) begin
                    dirty_clr = 1'b1;
                    state_d   = RD_REQ;
                end
            end
            RD_REQ, RD_WAIT: begin
                bus.Memstall_o   = 1'b1;
                bus.mem_enable_o = 1'b1;
                bus.mem_addr_o   = {addr_tag, idx, 5'b0};
                if (state_q == RD_REQ) begin
                    state_d = RD_WAIT;
                end else if (bus.mem_ack_i) begin
                    fill_we = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs must read zero for the whole reset pulse, even while a
        // request is presented to the still-held pipeline.
        if (rst_i) begin
            bus.Memstall_o   = 1'b0;
            bus.rdata_o      = '0;
            bus.mem_enable_o = 1'b0;
            bus.mem_write_o  = 1'b0;
            bus.mem_addr_o   = '0;
            bus.mem_data_o   = '0;
            store_we         = 1'b0;
            fill_we          = 1'b0;
            dirty_clr        = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (store_we) begin
                dirty_q[idx] <= 1'b1;
            end
            if (dirty_clr) begin
                dirty_q[idx] <= 1'b0;
            end
            if (fill_we) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
        end
    end

    // Tag and data arrays carry no reset; valid_q guards their contents.
    always_ff @(posedge clk_i) begin
        if (store_we) begin
            data_q[idx][{word_sel, 5'b0} +: 32] <= bus.wdata_i;
        end
        if (fill_we) begin
            data_q[idx] <= bus.mem_data_i;
            tag_q[idx]  <= addr_tag;
        end
    end
endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// tb_l1_dcache_ctrl -- self-checking bench for l1_dcache_ctrl.
// A line-level cache model plus a sparse backing memory predict hits, read
// data, write-back and fetch transactions for directed and random accesses.
module tb_l1_dcache_ctrl;
    localparam int INDEX_W = 4;
    localparam int LINES   = 16;
    localparam int TAG_W   = 23;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    l1_dcache_ctrl_if bus ();

    l1_dcache_ctrl #(.INDEX_W(INDEX_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    bit              m_valid [LINES];
    bit              m_dirty [LINES];
    logic [TAG_W-1:0] m_tag  [LINES];
    logic [255:0]    m_line  [LINES];
    logic [255:0]    mem     [int unsigned];

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] a);
        int unsigned key;
        key = {a[31:5], 5'b0};
        if (!mem.exists(key)) mem[key] = rand_line();
        return mem[key];
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endfunction

    // Plays the off-chip memory for one transaction; returns #1 after the ack edge.
    task automatic serve(input string tag, input bit exp_wr, input logic [31:0] exp_addr,
                         input logic [255:0] exp_data, input logic [255:0] resp);
        int  n = 0;
        bit  seen = 0;
        int  d;
        while (!seen && n < 6) begin
            @(negedge clk_i);
            n++;
            if (bus.mem_enable_o) seen = 1;
            else check_eq({tag, "_stall_pre"}, bus.Memstall_o, 1);
        end
        if (!seen) begin
            check_eq({tag, "_enable"}, bus.mem_enable_o, 1);
            return;
        end
        check_eq({tag, "_stall"}, bus.Memstall_o, 1);
        check_eq({tag, "_write"}, bus.mem_write_o, exp_wr);
        check_eq({tag, "_addr"}, bus.mem_addr_o, exp_addr);
        if (exp_wr) check_eq({tag, "_data"}, bus.mem_data_o, exp_data);
        @(posedge clk_i);
        d = $urandom_range(0, 3);
        repeat (d) begin
            @(negedge clk_i);
            check_eq({tag, "_held_en"}, bus.mem_enable_o, 1);
            check_eq({tag, "_held_addr"}, bus.mem_addr_o, exp_addr);
            @(posedge clk_i);
        end
        #1;
        bus.mem_ack_i  = 1'b1;
        bus.mem_data_i = resp;
        @(posedge clk_i);
        #1;
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = rand_line();
    endtask

    // op: 0 load, 1 store, 2 both strobes (acts as store). Starts and ends #1 after a posedge.
    task automatic access(input int op, input logic [31:0] a, input logic [31:0] wd);
        int unsigned       idx;
        logic [TAG_W-1:0]  tg;
        int                w;
        bit                hit;
        bit                done = 0;
        logic [31:0]       va, ra;
        logic [255:0]      nl;
        idx = a[8:5];
        tg  = a[31:9];
        w   = a[4:2];
        bus.MemRead_i  = (op != 1);
        bus.MemWrite_i = (op != 0);
        bus.addr_i     = a;
        bus.wdata_i    = wd;
        for (int tries = 0; tries < 3 && !done; tries++) begin
            @(negedge clk_i);
            hit = m_valid[idx] && (m_tag[idx] == tg);
            check_eq("idle_enable", bus.mem_enable_o, 0);
            if (hit) begin
                check_eq("hit_stall", bus.Memstall_o, 0);
                if (op == 0) check_eq("load_data", bus.rdata_o, m_line[idx][w*32 +: 32]);
                @(posedge clk_i);
                if (op != 0) begin
                    m_line[idx][w*32 +: 32] = wd;
                    m_dirty[idx] = 1'b1;
                end
                #1;
                done = 1;
            end else begin
                check_eq("miss_stall", bus.Memstall_o, 1);
                if (m_valid[idx] && m_dirty[idx]) begin
                    va = {m_tag[idx], idx[3:0], 5'b0};
                    serve("wb", 1, va, m_line[idx], rand_line());
                    mem[va] = m_line[idx];
                    m_dirty[idx] = 1'b0;
                end
                ra = {tg, idx[3:0], 5'b0};
                nl = mem_line(ra);
                serve("rd", 0, ra, '0, nl);
                m_line[idx]  = nl;
                m_tag[idx]   = tg;
                m_valid[idx] = 1'b1;
                m_dirty[idx] = 1'b0;
            end
        end
        if (!done) check_eq("access_never_hit", bus.Memstall_o, 0);
        bus.MemRead_i  = 1'b0;
        bus.MemWrite_i = 1'b0;
    endtask

    task automatic idle_cycle(input bit stray_ack);
        bus.MemRead_i  = 1'b0;
        bus.MemWrite_i = 1'b0;
        bus.addr_i     = $urandom;
        bus.mem_ack_i  = stray_ack;
        @(negedge clk_i);
        check_eq("idle_stall", bus.Memstall_o, 0);
        check_eq("idle_rdata", bus.rdata_o, 0);
        check_eq("idle_en", bus.mem_enable_o, 0);
        check_eq("idle_maddr", bus.mem_addr_o, 0);
        @(posedge clk_i);
        #1;
        bus.mem_ack_i = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_stall"}, bus.Memstall_o, 0);
        check_eq({tag, "_rdata"}, bus.rdata_o, 0);
        check_eq({tag, "_en"}, bus.mem_enable_o, 0);
        check_eq({tag, "_wr"}, bus.mem_write_o, 0);
        check_eq({tag, "_maddr"}, bus.mem_addr_o, 0);
        check_eq({tag, "_mdata"}, bus.mem_data_o, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] tmp;
        int           op;
        logic [TAG_W-1:0] tags [3];
        logic [31:0]  a;
        tags[0] = 23'h0;
        tags[1] = 23'h1;
        tags[2] = 23'h12345;

        bus.MemRead_i  = 1'b1;
        bus.MemWrite_i = 1'b0;
        bus.addr_i     = 32'h40;
        bus.wdata_i    = '0;
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = '0;
        rst_i          = 1'b1;
        model_clear();
        #2;
        check_outputs_zero("reset");
        bus.MemRead_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        tmp = mem_line(32'h40);
        tmp[95:64] = 32'hDEADBEEF;
        mem[32'h40] = tmp;

        access(0, 32'h40, 0);
        access(0, 32'h48, 0);
        access(1, 32'h44, 32'h12345678);
        access(0, 32'h44, 0);
        access(0, 32'h244, 0);
        access(0, 32'h40, 0);
        access(2, 32'h50, 32'hCAFEF00D);
        access(0, 32'h50, 0);
        access(0, 32'h250, 0);
        idle_cycle(1'b1);

        // Reset while the fetch is outstanding, then a stray ack.
        bus.MemRead_i = 1'b1;
        bus.addr_i    = 32'h440;
        @(negedge clk_i);
        check_eq("rst_mid_miss", bus.Memstall_o, 1);
        @(posedge clk_i);
        @(negedge clk_i);
        check_eq("rst_mid_rdreq_en", bus.mem_enable_o, 1);
        check_eq("rst_mid_rdreq_addr", bus.mem_addr_o, 32'h440);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        bus.MemRead_i = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        model_clear();
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        bus.mem_ack_i  = 1'b1;
        bus.mem_data_i = rand_line();
        @(posedge clk_i);
        #1;
        bus.mem_ack_i = 1'b0;
        @(negedge clk_i);
        check_eq("late_ack_stall", bus.Memstall_o, 0);
        check_eq("late_ack_en", bus.mem_enable_o, 0);
        @(posedge clk_i);
        #1;
        access(0, 32'h40, 0);
        access(0, 32'h440, 0);

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle_cycle($urandom_range(0, 1) == 1);
            end else begin
                op = $urandom_range(0, 2);
                a  = {tags[$urandom_range(0, 2)], 4'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b00};
                access(op, a, $urandom);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/l1_dcache_ctrl.md
L1_DCACHE_CTRL -- requirements
Module: l1_dcache_ctrl

Interface
REQ-001 Parameter INDEX_W, default 4, log2 of line count (16 lines); tag width SHALL be 27-INDEX_W bits.
REQ-002 clk_i  input  1  clock, all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 MemRead_i  input  1  MEM-stage load request.
REQ-005 MemWrite_i  input  1  MEM-stage store request.
REQ-006 addr_i  input  32  byte address; [4:2] word select, [INDEX_W+4:5] index, [31:INDEX_W+5] tag.
REQ-007 wdata_i  input  32  store data.
REQ-008 rdata_o  output  32  load data, valid on hit in IDLE.
REQ-009 Memstall_o  output  1  pipeline freeze to PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
REQ-010 mem_enable_o  output  1  off-chip request, held until ack.
REQ-011 mem_write_o  output  1  1 = line write-back, 0 = line fetch.
REQ-012 mem_addr_o  output  32  line-aligned address, bits [4:0] = 0.
REQ-013 mem_data_o  output  256  victim line during write-back.
REQ-014 mem_data_i  input  256  fill line, valid when mem_ack_i = 1.
REQ-015 mem_ack_i  input  1  one-cycle completion pulse from memory.

Function
REQ-016 Organisation: direct-mapped, 2^INDEX_W lines x 256 bits, per-line valid, dirty, tag; write-back, write-allocate.
REQ-017 Request = MemRead_i | MemWrite_i; both asserted SHALL be treated as a store.
REQ-018 Hit = valid[index] & (tag[index] == addr tag), evaluated combinationally in IDLE.
REQ-019 States: IDLE, WB_REQ, WB_WAIT, RD_REQ, RD_WAIT.
REQ-020 IDLE, no request: Memstall_o = 0, rdata_o = 0, no state change.
REQ-021 IDLE, load hit: rdata_o = selected word same cycle, Memstall_o = 0, zero-cycle latency.
REQ-022 IDLE, store hit: Memstall_o = 0; word written at next edge; dirty set.
REQ-023 IDLE, miss: Memstall_o = 1 same cycle; next state WB_REQ if valid & dirty, else RD_REQ.
REQ-024 WB_REQ: mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {old tag, index, 5'b0}, mem_data_o = victim line; next WB_WAIT.
REQ-025 WB_WAIT: outputs held as WB_REQ; on mem_ack_i go to RD_REQ, clear dirty.
REQ-026 RD_REQ: mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {addr tag, index, 5'b0}; next RD_WAIT.
REQ-027 RD_WAIT: outputs held; on mem_ack_i write mem_data_i into line, set valid, write tag, clear dirty, return IDLE.
REQ-028 After fill the retried access SHALL hit in IDLE; Memstall_o drops in that cycle.
REQ-029 Memstall_o SHALL be 1 in every non-IDLE state regardless of inputs.
REQ-030 mem_ack_i in IDLE, WB_REQ or RD_REQ SHALL be ignored.
REQ-031 mem_enable_o, mem_write_o, mem_addr_o, mem_data_o SHALL be 0 in IDLE.
REQ-032 addr_i, wdata_i, request SHALL be assumed stable while Memstall_o = 1 (pipeline frozen); block does not latch them.

Reset
REQ-033 rst_i SHALL force IDLE, clear all valid and dirty bits, and drive all outputs to 0 immediately.
REQ-034 Reset mid-transaction SHALL abandon it; a later mem_ack_i SHALL be ignored.
REQ-035 Data and tag arrays need not be cleared.

Verification
REQ-036 Cold load 0x0000_0040 -> Memstall_o = 1, RD_REQ addr 0x40, ack with word2 = 0xDEADBEEF; load 0x48 -> rdata_o = 0xDEADBEEF, stall 0.
REQ-037 Store hit 0x44 = 0x12345678, then load 0x44 -> 0x12345678, no mem_enable_o.
REQ-038 Dirty conflict: store 0x44, load 0x244 (INDEX_W = 4) -> write-back to 0x40 with stored word, then fetch 0x240, stall until fill ack.
REQ-039 Clean conflict: load 0x40, load 0x240 -> RD_REQ only, no write-back.
REQ-040 rst_i pulse in RD_WAIT -> IDLE, outputs 0, late ack ignored, load 0x40 misses again.
REQ-041 MemRead_i and MemWrite_i both 1 on hit -> store performed, dirty set.
